// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: round-robin, burst-limited arbiter for a shared single-port register file
// with one-cycle read return and write forwarding.
module rf_port_arbiter #(
    parameter int DATA_W    = 20,
    parameter int ADDR_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wr,
    output logic              rf_rd,
    input  logic [DATA_W-1:0] rf_rdata
);
    localparam int BW = $clog2(MAX_BURST + 1) > 2 ? $clog2(MAX_BURST + 1) : 2;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t            state;
    logic [BW-1:0]     bcnt;
    logic              last;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic              at_max;
    logic              g0;
    logic              g1;
    logic              cont;
    logic [DATA_W-1:0] rd_data;
    assign at_max = bcnt == BW'(MAX_BURST);
    always_comb begin
        g0 = state == OWN0 ? req0 && !(req1 && at_max)
           : state == OWN1 ? (req1 ? req0 && at_max : req0)
           : req0 && (!req1 || last);
        g1 = state == OWN1 ? req1 && !(req0 && at_max)
           : state == OWN0 ? (req0 ? req1 && at_max : req1)
           : req1 && (!req0 || !last);
        gnt0     = g0 && !reset;
        gnt1     = g1 && !reset;
        rf_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
        rf_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
        rf_wr    = gnt0 ? we0 : gnt1 && we1;
        rf_rd    = gnt0 ? !we0 : gnt1 && !we1;
        cont     = (gnt0 && state == OWN0) || (gnt1 && state == OWN1);
        // a write issued last cycle is not yet visible on rf_rdata
        rd_data  = fwd_valid && fwd_addr == rf_addr ? fwd_data : rf_rdata;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bcnt      <= '0;
            last      <= 1'b1;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state     <= gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
            bcnt      <= !(gnt0 || gnt1) ? '0 : cont ? (at_max ? bcnt : bcnt + BW'(1)) : BW'(1);
            if (gnt0 || gnt1)
                last <= gnt1;
            fwd_valid <= rf_wr;
            if (rf_wr) begin
                fwd_addr <= rf_addr;
                fwd_data <= rf_wdata;
            end
            rvalid0   <= gnt0 && rf_rd;
            rvalid1   <= gnt1 && rf_rd;
            if (gnt0 && rf_rd)
                rdata0 <= rd_data;
            if (gnt1 && rf_rd)
                rdata1 <= rd_data;
        end
    end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed scoreboard bench with a delayed-commit register file model.
module tb_rf_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [19:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [19:0] rdata0, rdata1;
    logic [3:0]  rf_addr;
    logic [19:0] rf_wdata;
    logic        rf_wr, rf_rd;
    logic [19:0] rf_rdata;
    logic [19:0] mem [16];
    logic [19:0] shadow [16];
    logic        pv, pre_v;
    logic [3:0]  pa, pre_a;
    logic [19:0] pd, pre_d;
    logic [19:0] q0 [$];
    logic [19:0] q1 [$];
    int          total = 0;
    int          bad = 0;

    rf_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_wr(rf_wr), .rf_rd(rf_rd),
        .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // register file: a write issued in cycle t lands in mem at the end of cycle t+1
    always @(posedge clk) begin
        if (pre_v) mem[pre_a] <= pre_d;
        if (pv) mem[pa] <= pd;
        pv <= rf_wr;
        pa <= rf_addr;
        pd <= rf_wdata;
    end
    assign rf_rdata = mem[rf_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid0) begin
            if (q0.size() == 0) chk("rvalid0_unexpected", 32'(rvalid0), 0);
            else chk("rdata0", 32'(rdata0), 32'(q0.pop_front()));
        end
        if (rvalid1) begin
            if (q1.size() == 0) chk("rvalid1_unexpected", 32'(rvalid1), 0);
            else chk("rdata1", 32'(rdata1), 32'(q1.pop_front()));
        end
    end

    task automatic step(input int r0, w0, a0, d0, r1, w1, a1, d1, e0, e1);
        logic        ew;
        logic [3:0]  ea;
        logic [19:0] ed;
        req0 = r0 != 0; we0 = w0 != 0; addr0 = 4'(a0); wdata0 = 20'(d0);
        req1 = r1 != 0; we1 = w1 != 0; addr1 = 4'(a1); wdata1 = 20'(d1);
        #3;
        ew = e0 != 0 ? we0 : e1 != 0 && we1;
        ea = e0 != 0 ? addr0 : e1 != 0 ? addr1 : 4'h0;
        ed = e0 != 0 ? wdata0 : e1 != 0 ? wdata1 : 20'h0;
        chk("gnt0", 32'(gnt0), 32'(e0));
        chk("gnt1", 32'(gnt1), 32'(e1));
        chk("rf_wr", 32'(rf_wr), 32'(ew));
        chk("rf_rd", 32'(rf_rd), 32'((e0 != 0 || e1 != 0) && !ew));
        chk("rf_addr", 32'(rf_addr), 32'(ea));
        chk("rf_wdata", 32'(rf_wdata), 32'(ed));
        if (e0 != 0 && !we0) q0.push_back(shadow[addr0]);
        if (e1 != 0 && !we1) q1.push_back(shadow[addr1]);
        if (e0 != 0 && we0) shadow[addr0] = wdata0;
        if (e1 != 0 && we1) shadow[addr1] = wdata1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'd3; addr1 = 4'd6;
        #3;
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rvalid1", 32'(rvalid1), 0);
        chk("rst_rdata0", 32'(rdata0), 0);
        chk("rst_rdata1", 32'(rdata1), 0);
        chk("rst_rf_addr", 32'(rf_addr), 0);
        chk("rst_rf_wdata", 32'(rf_wdata), 0);
        chk("rst_rf_wr", 32'(rf_wr), 0);
        chk("rst_rf_rd", 32'(rf_rd), 0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int pre_addr [3] = '{3, 6, 7};
        int pre_data [3] = '{'h0ABCD, 'h12345, 'h00111};
        reset = 1'b1; pre_v = 1'b0; pre_a = 4'h0; pre_d = 20'h0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 20'h0; wdata1 = 20'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            pre_v = 1'b1; pre_a = 4'(pre_addr[i]); pre_d = 20'(pre_data[i]);
            shadow[pre_a] = pre_d;
            @(posedge clk); #1;
        end
        pre_v = 1'b0;
        do_reset();
        // lone read, zero-latency grant and one-cycle return
        step(1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // contended from reset: bursts of four, no bubbles
        do_reset();
        for (int i = 0; i < 9; i++)
            step(1, 0, 3, 0, 1, 0, 6, 0, pat[i] == 0, pat[i] == 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // write-then-read forwarding and its address miss
        step(0, 0, 0, 0, 1, 1, 7, 'hFFFFF, 0, 1);
        step(0, 0, 0, 0, 1, 0, 7, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 7, 'h0000A, 0, 1);
        step(0, 0, 0, 0, 1, 0, 6, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 7, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lone owner saturates, late contender is served at once
        for (int i = 0; i < 10; i++)
            step(1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 3, 0, 1, 0, 6, 0, 0, 1);
        step(1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        // owner drop hands over with burst count restarted
        step(1, 0, 3, 0, 1, 0, 6, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 6, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            step(1, 0, 3, 0, 1, 0, 6, 0, 0, 1);
        step(1, 0, 3, 0, 1, 0, 6, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset with a read in flight, then contended restart favours requester 0
        step(0, 0, 0, 0, 1, 0, 7, 0, 0, 1);
        do_reset();
        step(1, 0, 3, 0, 1, 0, 6, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Two-requester arbiter and sequencer for the shared single-port 20-bit register file. It grants at most one access per cycle and drives the register file's address, data, write and read strobes. It returns read data to the winning requester with a fixed one-cycle latency. It forwards write data to hide the register file's one-cycle write-commit delay, and enforces round-robin fairness with a bounded burst length.

## Interface
Parameters:
- DATA_W, 20, data width of register file entries
- ADDR_W, 4, register file address width
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester waits (≥1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- req0 / req1  input  1  access request from requester 0 / 1
- we0 / we1  input  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  input  ADDR_W  target address; valid while req high
- wdata0 / wdata1  input  DATA_W  write data; valid while req high and we high
- gnt0 / gnt1  output  1  combinational grant; access issued in this cycle
- rvalid0 / rvalid1  output  1  registered one-cycle pulse, read data valid
- rdata0 / rdata1  output  DATA_W  registered read data, held until next rvalid for that port
- rf_addr  output  ADDR_W  register file address
- rf_wdata  output  DATA_W  register file write data
- rf_wr  output  1  register file write strobe
- rf_rd  output  1  register file read strobe
- rf_rdata  input  DATA_W  register file combinational read data for rf_addr

## Operation
- State machine: IDLE, OWN0, OWN1. A 2-bit-or-wider burst counter bcnt and a last-owner bit last are kept.
- IDLE:
  - If neither requester is asserting, stay in IDLE with no grant.
  - If exactly one requester asserts, grant it.
  - If both assert, grant the one ≠ last.
  - On grant: go to OWNn, set bcnt=1, set last=n.
- OWNn, req n high, other req high, bcnt<MAX_BURST: grant n, bcnt++.
- OWNn, req n high, other req high, bcnt==MAX_BURST: grant the other requester m in the same cycle, go to OWNm, set bcnt=1, set last=m.
- OWNn, req n high, other req low: grant n, saturate bcnt at MAX_BURST (the owner continues unthrottled).
- OWNn, req n low:
  - If the other requester is asserting, grant it, go to OWNm, set bcnt=1.
  - Otherwise go to IDLE with no grant.
- Exactly one of gnt0/gnt1 is high in any issue cycle; both are low otherwise. A requester holds req, we, addr and wdata stable until it samples its gnt high at a clock edge. It may drop or change them in the next cycle.
- Issue cycle mux:
  - rf_addr = granted addr.
  - rf_wr = granted we.
  - rf_rd = granted !we.
  - rf_wdata = granted wdata.
  - When no grant: rf_wr=0, rf_rd=0, rf_addr/rf_wdata = 0.
- Write commit: the register file commits a write at the edge after the issue cycle, and it is visible on rf_rdata one cycle later.
  - The arbiter keeps fwd_valid, fwd_addr and fwd_data, loaded on every issued write and cleared on any cycle without a write.
- Read forwarding: if a read issues with fwd_valid && fwd_addr==rf_addr, the returned data is fwd_data. Otherwise it is rf_rdata.
- Read return: returned data is registered into rdata of the granted port, and that port's rvalid pulses for one cycle.
- Writes produce no rvalid.

## Timing
- Grant latency: 0 cycles from req in IDLE or on owner continuation. The other requester waits at most MAX_BURST issue cycles.
- Read latency: rvalid/rdata one cycle after the gnt cycle.
- Throughput: one access per cycle. Back-to-back reads or writes from the same or alternating requesters run with no bubble.
- Write-then-read to the same address in consecutive cycles returns the new data via forwarding.
- Reset (asynchronous, any cycle, including mid-burst or with a read in flight):
  - Outputs: gnt*=0, rvalid*=0, rdata*=0, rf_*=0.
  - State: state=IDLE, bcnt=0, last=1 (so requester 0 wins the first contended grant), fwd_valid=0.
  - An in-flight rvalid is dropped.
- At deassertion of reset, arbitration resumes in the first cycle.

## Test plan
- Reset, then req0 read addr 3 alone (rf holds 0x0ABCD at addr 3): gnt0 in cycle 0, rf_rd=1, rf_addr=3; rvalid0=1 and rdata0=0x0ABCD in cycle 1.
- Both requesters request from IDLE after reset: gnt0 first.
  - With both held continuously and MAX_BURST=4: grants run 0,0,0,0,1,1,1,1,0, with no idle cycles.
- req1 writes 0xFFFFF to addr 7, then req1 reads addr 7 the next cycle: rf_wr then rf_rd issue back-to-back; rdata1=0xFFFFF via forwarding.
  - A read of addr 6 in the same position returns rf_rdata instead.
- req0 alone for 10 cycles: gnt0 every cycle, bcnt saturates.
  - req1 raised in cycle 10 is granted no later than cycle 14.
- Assert reset in the cycle after a read grant: rvalid never pulses, all outputs 0.
  - After release, a contended request grants requester 0.
- Owner drops req while the other is asserting: handover occurs in the same cycle with no bubble, and bcnt restarts at 1.
